writeback_unit: RTL and testbench

//  Registered, parametrised writeback stage of the RISC-V core; successor to the single-cycle writeback mux.
//  - Selects the rd write value per CU opcode: ALU, LUI, AUIPC, link (PC+4), or an extended load.
//  - Loads run as multi-cycle data-memory transactions: req/ack handshake, byte-lane alignment,

---
 rtl/cpu_types_pkg.sv | 40 ++++
 rtl/load_extract.sv | 36 +++
 rtl/writeback_unit.sv | 145 ++++++++++++++
 tb/tb_writeback_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared control-unit opcode and writeback-state types.
// Also holds small classification helpers used by the writeback stage.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_ADD, CU_SUB, CU_XOR, CU_OR, CU_AND,
        CU_SLL, CU_SRL, CU_SRA, CU_SLT, CU_SLTU,
        CU_SB, CU_SH, CU_SW,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU
    } cu_op_t;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_t;

    function automatic logic is_load(cu_op_t op);
        return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
    endfunction

    function automatic logic is_alu(cu_op_t op);
        return op inside {CU_ADD, CU_SUB, CU_XOR, CU_OR, CU_AND,
                          CU_SLL, CU_SRL, CU_SRA, CU_SLT, CU_SLTU};
    endfunction

    // Halfwords need an even byte address, words a multiple of four.
    function automatic logic load_aligned(cu_op_t op, logic [1:0] lane);
        logic ok;
        ok = 1'b1;
        case (op)
            CU_LH, CU_LHU: ok = (lane[0] == 1'b0);
            CU_LW:         ok = (lane == 2'b00);
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane select and sign/zero extension of a memory read word.
module load_extract
    import cpu_types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            data,
    input  logic [$clog2(XLEN/8)-1:0]  lane,
    input  logic [5:0]                 op,
    output logic [XLEN-1:0]            result
);

    logic [$clog2(XLEN/8)+2:0] shamt;
    logic [7:0]                b;
    logic [15:0]               h;
    logic [31:0]               w;

    assign shamt = {lane, 3'b000};
    assign b     = 8'(data >> shamt);
    assign h     = 16'(data >> shamt);
    assign w     = 32'(data >> shamt);

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = '0;
        case (cu_op_t'(op))
            CU_LB:   result = {{(XLEN-8){b[7]}}, b};
            CU_LH:   result = {{(XLEN-16){h[15]}}, h};
            CU_LW:   result = XLEN'($signed(w));
            CU_LBU:  result = XLEN'(b);
            CU_LHU:  result = XLEN'(h);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Registered writeback stage: result select, multi-cycle loads with alignment
// trap and timeout, and a one-cycle-latency register-file write port.
module writeback_unit
    import cpu_types_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        cu_op,
    input  logic [REG_AW-1:0] rd,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              busy
);

    localparam int LANE_W = $clog2(XLEN/8);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    wb_state_t           state;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [LANE_W-1:0]   ld_lane;
    logic [5:0]          ld_op;
    logic [REG_AW-1:0]   ld_rd;

    cu_op_t              op;
    logic [XLEN-1:0]     u_imm;
    logic [XLEN-1:0]     op_result;
    logic                op_writes;
    logic [XLEN-1:0]     ld_data;

    assign op       = cu_op_t'(cu_op);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign u_imm    = imm & ~XLEN'(12'hFFF);

    always_comb begin
        op_result = alu_out;
        op_writes = 1'b0;
        case (op)
            CU_LUI: begin
                op_result = u_imm;
                op_writes = 1'b1;
            end
            CU_AUIPC: begin
                op_result = pc + u_imm;
                op_writes = 1'b1;
            end
            CU_JAL, CU_JALR: begin
                op_result = pc + XLEN'(4);
                op_writes = 1'b1;
            end
            default: begin
                op_result = alu_out;
                op_writes = is_alu(op);
            end
        endcase
    end

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .data   (mem_rdata),
        .lane   (ld_lane),
        .op     (ld_op),
        .result (ld_data)
    );

    always_ff @(posedge clk) begin
        if (nRST) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            ld_lane      <= '0;
            ld_op        <= '0;
            ld_rd        <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            rf_we        <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_load(op)) begin
                            if (!load_aligned(op, alu_out[1:0])) begin
                                misalign_err <= 1'b1;
                            end else begin
                                state    <= WAIT_MEM;
                                mem_req  <= 1'b1;
                                mem_addr <= alu_out & ~XLEN'((XLEN/8) - 1);
                                tmo_cnt  <= '0;
                                ld_lane  <= alu_out[LANE_W-1:0];
                                ld_op    <= cu_op;
                                ld_rd    <= rd;
                            end
                        end else if (op_writes && rd != '0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= op_result;
                        end
                    end
                end
                WAIT_MEM: begin
                    // An ack in the timeout cycle still completes the load.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (ld_rd != '0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ld_rd;
                            rf_wdata <= ld_data;
                        end
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit (XLEN=32, TIMEOUT_CYCLES=4): stimulus pushes
// expected events, a negedge monitor pops and compares them.
module tb_writeback_unit;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        nRST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  cu_op = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_out = '0, imm = '0, pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        misalign_err, timeout_err, busy;

    writeback_unit #(.XLEN(32), .REG_AW(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .cu_op(cu_op), .rd(rd), .alu_out(alu_out), .imm(imm), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .misalign_err(misalign_err), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 write, 1 misalign, 2 timeout
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   req_cycles = 0;
    int   we_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_event(input int kind, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == 0 && e.kind == 0) begin
                check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                check("rf_wdata", rf_wdata, e.data);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, compares every output event against the queue.
    always @(negedge clk) begin
        if (!nRST) begin
            if (mem_req) req_cycles++;
            if (rf_we) begin
                we_cycles++;
                pop_event(0);
            end
            if (misalign_err) pop_event(1);
            if (timeout_err)  pop_event(2);
        end
    end

    task automatic issue(input cu_op_t op, input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] i, input logic [31:0] p);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_wait: in_ready 0 expected 1 within 50 cycles");
        end
        cu_op    = op;
        rd       = r;
        alu_out  = a;
        imm      = i;
        pc       = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic ack_after(input int d, input logic [31:0] data);
        repeat (d) @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;

        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b0;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_rf_wdata", rf_wdata, 0);

        // 1: LB lane 1, ack two cycles after request
        expect_event(0, 5'd1, 32'hFFFF_FF80);
        issue(CU_LB, 5'd1, 32'h0000_0101, 0, 0);
        check("lb_mem_req", 32'(mem_req), 1);
        check("lb_mem_addr", mem_addr, 32'h0000_0100);
        check("lb_in_ready", 32'(in_ready), 0);
        ack_after(2, 32'hAAAA_80AA);
        check("lb_latency_we", 32'(rf_we), 1);
        check("lb_mem_req_drop", 32'(mem_req), 0);

        // 2: LHU upper half, misaligned LH and LW, other extensions
        expect_event(0, 5'd2, 32'h0000_BEEF);
        issue(CU_LHU, 5'd2, 32'h0000_0202, 0, 0);
        ack_after(0, 32'hBEEF_1234);
        expect_event(1, 0, 0);
        issue(CU_LH, 5'd3, 32'h0000_0201, 0, 0);
        check("lh_mis_pulse", 32'(misalign_err), 1);
        check("lh_mis_no_req", 32'(mem_req), 0);
        expect_event(1, 0, 0);
        issue(CU_LW, 5'd3, 32'h0000_0502, 0, 0);
        expect_event(0, 5'd3, 32'hFFFF_8001);
        issue(CU_LH, 5'd3, 32'h0000_0402, 0, 0);
        ack_after(1, 32'h8001_5555);
        expect_event(0, 5'd4, 32'h0000_007F);
        issue(CU_LB, 5'd4, 32'h0000_0403, 0, 0);
        ack_after(0, 32'h7F00_0000);
        expect_event(0, 5'd4, 32'h0000_00F0);
        issue(CU_LBU, 5'd4, 32'h0000_0400, 0, 0);
        ack_after(0, 32'h0000_00F0);

        // 3: U-type and link results
        expect_event(0, 5'd4, 32'h0000_B000);
        issue(CU_AUIPC, 5'd4, 0, 32'h0000_A000, 32'h0000_1000);
        check("auipc_latency_we", 32'(rf_we), 1);
        expect_event(0, 5'd5, 32'h0000_0000);
        issue(CU_JALR, 5'd5, 0, 0, 32'hFFFF_FFFC);
        expect_event(0, 5'd6, 32'h1234_5000);
        issue(CU_LUI, 5'd6, 0, 32'h1234_5ABC, 0);
        expect_event(0, 5'd7, 32'h0000_0104);
        issue(CU_JAL, 5'd7, 0, 0, 32'h0000_0100);

        // 4: timeout after exactly four request cycles, then ack on the fourth cycle
        start = req_cycles;
        expect_event(2, 0, 0);
        issue(CU_LW, 5'd5, 32'h0000_0300, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        check("tmo_req_cycles", 32'(req_cycles - start), 4);
        check("tmo_idle", 32'(busy), 0);
        expect_event(0, 5'd5, 32'h1122_3344);
        issue(CU_LW, 5'd5, 32'h0000_0300, 0, 0);
        ack_after(3, 32'h1122_3344);
        check("ack4_we", 32'(rf_we), 1);
        @(posedge clk);
        #1;
        check("ack4_no_tmo", 32'(timeout_err), 0);

        // 5: rd=0 suppresses the write; stores/branches write nothing; back-to-back ALU ops
        issue(CU_ADD, 5'd0, 32'h0000_1234, 0, 0);
        check("rd0_no_we", 32'(rf_we), 0);
        check("rd0_in_ready", 32'(in_ready), 1);
        check("hold_wdata", rf_wdata, 32'h1122_3344);
        check("hold_waddr", 32'(rf_waddr), 5);
        issue(CU_SW, 5'd9, 32'h0000_0010, 0, 0);
        issue(CU_BEQ, 5'd9, 32'h0000_0020, 0, 0);
        check("store_branch_no_we", 32'(rf_we), 0);
        start = we_cycles;
        expect_event(0, 5'd6, 32'h0000_0001);
        expect_event(0, 5'd7, 32'h0000_0002);
        expect_event(0, 5'd8, 32'h0000_0003);
        issue(CU_ADD, 5'd6, 32'h0000_0001, 0, 0);
        issue(CU_SUB, 5'd7, 32'h0000_0002, 0, 0);
        issue(CU_XOR, 5'd8, 32'h0000_0003, 0, 0);
        @(posedge clk);
        #1;
        check("b2b_we_cycles", 32'(we_cycles - start), 3);

        // 6: reset in WAIT_MEM, then a late ack
        issue(CU_LW, 5'd10, 32'h0000_0600, 0, 0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        @(posedge clk);
        #1;
        nRST = 1'b0;
        check("mid_rst_mem_req", 32'(mem_req), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_waddr", 32'(rf_waddr), 0);
        check("mid_rst_wdata", rf_wdata, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("late_ack_no_we", 32'(rf_we), 0);
        check("late_ack_idle", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
